// File: rtl/sw_debounce_m.sv
// Switch input conditioner: two-flop synchroniser per bit, shared prescaled tick,
// per-bit debounce counters, registered level plus rise/fall/any-change strobes.
module sw_debounce_m #(
    parameter int              SW_W           = 8,
    parameter int              PRESCALE       = 1000,
    parameter int              DEBOUNCE_TICKS = 16,
    parameter logic [SW_W-1:0] RST_VAL        = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] sw_in,
    output logic [SW_W-1:0] sw_q,
    output logic [SW_W-1:0] sw_rise,
    output logic [SW_W-1:0] sw_fall,
    output logic            sw_chg
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_TICKS - 1);

    // Each bit is an independent switch, so per-bit synchronisation is sufficient.
    logic [SW_W-1:0] sync1_q, sync1_d;
    logic [SW_W-1:0] sync2_q, sync2_d;
    logic [SW_W-1:0] sw_d;
    logic [SW_W-1:0] rise_q, rise_d;
    logic [SW_W-1:0] fall_q, fall_d;
    logic            chg_q, chg_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [CW-1:0]   cnt_q [SW_W];
    logic [CW-1:0]   cnt_d [SW_W];
    logic            tick;

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        sync1_d = sw_in;
        sync2_d = sync1_q;
        sw_d    = sw_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < SW_W; i++) begin
            cnt_d[i] = cnt_q[i];
            // Any cycle where the input agrees with the accepted level restarts the count.
            if (sync2_q[i] == sw_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_LAST) begin
                    sw_d[i]   = sync2_q[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = sync2_q[i];
                    fall_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        chg_d = |{rise_d, fall_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            sw_q    <= RST_VAL;
            rise_q  <= '0;
            fall_q  <= '0;
            chg_q   <= 1'b0;
            presc_q <= '0;
            for (int i = 0; i < SW_W; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sw_q    <= sw_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            chg_q   <= chg_d;
            presc_q <= presc_d;
            for (int i = 0; i < SW_W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_rise = rise_q;
    assign sw_fall = fall_q;
    assign sw_chg  = chg_q;

endmodule

// File: tb/tb_sw_debounce_m.sv
// Bench for sw_debounce_m: a fast instance (PRESCALE=1, 4 ticks) and a prescaled
// instance (PRESCALE=10, 3 ticks) checked against a behavioural model.
module tb_sw_debounce_m;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_a, in_b;
    logic [7:0] q_a, rise_a, fall_a;
    logic [7:0] q_b, rise_b, fall_b;
    logic       chg_a, chg_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sw_debounce_m #(.SW_W(8), .PRESCALE(1), .DEBOUNCE_TICKS(4), .RST_VAL(8'h00)) dut_a (
        .clk(clk), .rst(rst), .sw_in(in_a), .sw_q(q_a),
        .sw_rise(rise_a), .sw_fall(fall_a), .sw_chg(chg_a)
    );

    sw_debounce_m #(.SW_W(8), .PRESCALE(10), .DEBOUNCE_TICKS(3), .RST_VAL(8'h00)) dut_b (
        .clk(clk), .rst(rst), .sw_in(in_b), .sw_q(q_b),
        .sw_rise(rise_b), .sw_fall(fall_b), .sw_chg(chg_b)
    );

    // Behavioural model: index 0 mirrors dut_a, index 1 mirrors dut_b.
    int         m_cyc [2];
    int         m_run [2][8];
    logic [7:0] m_hist1 [2];
    logic [7:0] m_hist2 [2];
    logic [7:0] m_q [2];
    logic [7:0] m_rise [2];
    logic [7:0] m_fall [2];
    logic       m_chg [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 0;
            m_hist1[i] = 8'h00;
            m_hist2[i] = 8'h00;
            m_q[i] = 8'h00;
            m_rise[i] = 8'h00;
            m_fall[i] = 8'h00;
            m_chg[i] = 1'b0;
            for (int b = 0; b < 8; b++) m_run[i][b] = 0;
        end
    endtask

    // Seen value = input sampled two edges ago; a change is accepted once it has
    // persisted through the required number of tick cycles.
    task automatic model_step(input int i, input logic [7:0] din);
        int         pr;
        int         need;
        logic       tick;
        logic [7:0] seen;
        pr   = (i == 0) ? 1 : 10;
        need = (i == 0) ? 4 : 3;
        tick = ((m_cyc[i] % pr) == pr - 1);
        seen = m_hist2[i];
        m_rise[i] = 8'h00;
        m_fall[i] = 8'h00;
        for (int b = 0; b < 8; b++) begin
            if (seen[b] == m_q[i][b]) begin
                m_run[i][b] = 0;
            end else if (tick) begin
                m_run[i][b] = m_run[i][b] + 1;
                if (m_run[i][b] == need) begin
                    m_run[i][b] = 0;
                    m_q[i][b] = seen[b];
                    if (seen[b]) m_rise[i][b] = 1'b1;
                    else m_fall[i][b] = 1'b1;
                end
            end
        end
        m_chg[i] = (m_rise[i] != 8'h00) || (m_fall[i] != 8'h00);
        m_hist2[i] = m_hist1[i];
        m_hist1[i] = din;
        m_cyc[i] = m_cyc[i] + 1;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) begin
            model_step(0, in_a);
            model_step(1, in_b);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_a = 8'h00;
        in_b = 8'h00;
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step();
            n_checks++;
            if ({q_a, rise_a, fall_a, chg_a, q_b, rise_b, fall_b, chg_b} !== 50'h0) begin
                n_fail++;
                $display("FAIL reset_idle n=%0d a=%h/%h/%h/%b b=%h/%h/%h/%b want all 0",
                         n, q_a, rise_a, fall_a, chg_a, q_b, rise_b, fall_b, chg_b);
            end
        end
    endtask

    task automatic test_step();
        int rise_n = -1;
        int pulses = 0;
        in_a = 8'h01;
        for (int n = 1; n <= 12; n++) begin
            step();
            n_checks++;
            if ({q_a, rise_a, fall_a, chg_a} !== {m_q[0], m_rise[0], m_fall[0], m_chg[0]}) begin
                n_fail++;
                $display("FAIL step_model n=%0d got %h/%h/%h/%b want %h/%h/%h/%b", n,
                         q_a, rise_a, fall_a, chg_a, m_q[0], m_rise[0], m_fall[0], m_chg[0]);
            end
            if (chg_a) pulses++;
            if (rise_a != 8'h00) rise_n = n;
        end
        n_checks++;
        if (rise_n != 6 || pulses != 1) begin
            n_fail++;
            $display("FAIL step_latency got rise at %0d pulses %0d want 6 and 1", rise_n, pulses);
        end
        n_checks++;
        if (q_a !== 8'h01) begin
            n_fail++;
            $display("FAIL step_level got %h want 01", q_a);
        end
    endtask

    task automatic test_glitch();
        int rises = 0;
        int falls = 0;
        int fall_n = -1;
        in_a[3] = 1'b1;
        repeat (3) step();
        in_a[3] = 1'b0;
        repeat (12) step();
        n_checks++;
        if ({q_a, rise_a, fall_a, chg_a} !== {8'h01, 8'h00, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL glitch_reject got %h/%h/%h/%b want 01/00/00/0", q_a, rise_a, fall_a, chg_a);
        end
        in_a[3] = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            if (rise_a[3]) rises++;
        end
        in_a[3] = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            step();
            n_checks++;
            if ({q_a, rise_a, fall_a, chg_a} !== {m_q[0], m_rise[0], m_fall[0], m_chg[0]}) begin
                n_fail++;
                $display("FAIL glitch_model n=%0d got %h/%h/%h/%b want %h/%h/%h/%b", n,
                         q_a, rise_a, fall_a, chg_a, m_q[0], m_rise[0], m_fall[0], m_chg[0]);
            end
            if (rise_a[3]) rises++;
            if (fall_a[3]) begin
                falls++;
                fall_n = n;
            end
        end
        n_checks++;
        if (rises != 1 || falls != 1 || fall_n != 6) begin
            n_fail++;
            $display("FAIL glitch_accept got rises %0d falls %0d fall at %0d want 1 1 6",
                     rises, falls, fall_n);
        end
    endtask

    task automatic test_multi();
        int   pulses = 0;
        logic [7:0] rise_seen = 8'h00;
        logic [7:0] fall_seen = 8'h00;
        in_a = 8'h00;
        repeat (10) step();
        in_a = 8'hA5;
        for (int n = 0; n < 12; n++) begin
            step();
            if (chg_a) begin
                pulses++;
                rise_seen = rise_a;
            end
            fall_seen = fall_seen | fall_a;
        end
        n_checks++;
        if (q_a !== 8'hA5 || rise_seen !== 8'hA5 || fall_seen !== 8'h00 || pulses != 1) begin
            n_fail++;
            $display("FAIL multi_bit got q %h rise %h fall %h pulses %0d want A5 A5 00 1",
                     q_a, rise_seen, fall_seen, pulses);
        end
    endtask

    task automatic test_prescale();
        int acc_n = -1;
        int acc_ph = -1;
        for (int t = 0; t < 90; t++) begin
            in_b[0] = ((t / 15) % 2 == 0);
            step();
            n_checks++;
            if ({q_b, rise_b, fall_b, chg_b} !== {m_q[1], m_rise[1], m_fall[1], m_chg[1]} ||
                q_b !== 8'h00 || chg_b !== 1'b0) begin
                n_fail++;
                $display("FAIL presc_toggle t=%0d got %h/%h/%h/%b want 00/00/00/0",
                         t, q_b, rise_b, fall_b, chg_b);
            end
        end
        in_b = 8'h01;
        for (int n = 1; n <= 40; n++) begin
            step();
            n_checks++;
            if ({q_b, rise_b, fall_b, chg_b} !== {m_q[1], m_rise[1], m_fall[1], m_chg[1]}) begin
                n_fail++;
                $display("FAIL presc_model n=%0d got %h/%h/%h/%b want %h/%h/%h/%b", n,
                         q_b, rise_b, fall_b, chg_b, m_q[1], m_rise[1], m_fall[1], m_chg[1]);
            end
            if (rise_b[0] && acc_n < 0) begin
                acc_n = n;
                acc_ph = (m_cyc[1] - 1) % 10;
            end
        end
        n_checks++;
        if (acc_n < 1 || acc_n > 33 || acc_ph != 9 || q_b !== 8'h01) begin
            n_fail++;
            $display("FAIL presc_accept got n %0d phase %0d q %h want n<=33 phase 9 q 01",
                     acc_n, acc_ph, q_b);
        end
    endtask

    task automatic test_async_reset();
        int rise_n = -1;
        int pulses_a = 0;
        int pulses_b = 0;
        logic [7:0] rise_seen = 8'h00;
        in_a = 8'hFF;
        in_b = 8'hFF;
        repeat (3) step();
        @(posedge clk);
        model_step(0, in_a);
        model_step(1, in_b);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({q_a, rise_a, fall_a, chg_a, q_b, rise_b, fall_b, chg_b} !== 50'h0) begin
            n_fail++;
            $display("FAIL async_clear got a %h/%h/%h/%b b %h/%h/%h/%b want all 0",
                     q_a, rise_a, fall_a, chg_a, q_b, rise_b, fall_b, chg_b);
        end
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            step();
            n_checks++;
            if ({q_a, chg_a, q_b, chg_b} !== 18'h0) begin
                n_fail++;
                $display("FAIL in_reset n=%0d got q_a %h chg_a %b q_b %h chg_b %b want 0",
                         n, q_a, chg_a, q_b, chg_b);
            end
        end
        rst = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            step();
            n_checks++;
            if ({q_a, rise_a, fall_a, chg_a, q_b, rise_b, fall_b, chg_b} !==
                {m_q[0], m_rise[0], m_fall[0], m_chg[0], m_q[1], m_rise[1], m_fall[1], m_chg[1]}) begin
                n_fail++;
                $display("FAIL post_reset_model n=%0d a %h/%h/%h b %h/%h/%h want a %h/%h/%h b %h/%h/%h", n,
                         q_a, rise_a, fall_a, q_b, rise_b, fall_b,
                         m_q[0], m_rise[0], m_fall[0], m_q[1], m_rise[1], m_fall[1]);
            end
            if (chg_a) begin
                pulses_a++;
                rise_n = n;
                rise_seen = rise_a;
            end
            if (chg_b) pulses_b++;
        end
        n_checks++;
        if (rise_n != 6 || rise_seen !== 8'hFF || pulses_a != 1 || pulses_b != 1 ||
            q_a !== 8'hFF || q_b !== 8'hFF) begin
            n_fail++;
            $display("FAIL post_reset_accept got n %0d rise %h pulses %0d/%0d q %h/%h want 6 FF 1/1 FF/FF",
                     rise_n, rise_seen, pulses_a, pulses_b, q_a, q_b);
        end
    endtask

    task automatic test_random();
        int hold_a = 0;
        int hold_b = 0;
        for (int n = 0; n < 600; n++) begin
            if (hold_a == 0) begin
                in_a = 8'($urandom);
                hold_a = $urandom_range(1, 12);
            end
            if (hold_b == 0) begin
                in_b = 8'($urandom);
                hold_b = $urandom_range(1, 45);
            end
            hold_a--;
            hold_b--;
            step();
            n_checks++;
            if ({q_a, rise_a, fall_a, chg_a, q_b, rise_b, fall_b, chg_b} !==
                {m_q[0], m_rise[0], m_fall[0], m_chg[0], m_q[1], m_rise[1], m_fall[1], m_chg[1]}) begin
                n_fail++;
                $display("FAIL random_model n=%0d a %h/%h/%h/%b b %h/%h/%h/%b want a %h/%h/%h/%b b %h/%h/%h/%b",
                         n, q_a, rise_a, fall_a, chg_a, q_b, rise_b, fall_b, chg_b,
                         m_q[0], m_rise[0], m_fall[0], m_chg[0], m_q[1], m_rise[1], m_fall[1], m_chg[1]);
            end
            n_checks++;
            if ((rise_a & fall_a) != 8'h00 || (rise_b & fall_b) != 8'h00) begin
                n_fail++;
                $display("FAIL random_exclusive n=%0d a %h&%h b %h&%h want 00",
                         n, rise_a, fall_a, rise_b, fall_b);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_a = 8'h00;
        in_b = 8'h00;
        model_reset();
        @(negedge clk);
        test_reset();
        test_step();
        test_glitch();
        test_multi();
        test_prescale();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
